// File: rtl/spio_hss_multiplexer_frame_assembler.sv
// Frame assembler: requests packets from all channel stores, builds one frame per slot and
// tracks the ack/nak window. Optional counters enabled by SPIO_HSS_FRM_ASM_STATS_EN.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif
`ifndef SEQ_BITS
`define SEQ_BITS 7
`endif
`ifndef BUF_LEN
`define BUF_LEN 8
`endif

module spio_hss_multiplexer_frame_assembler #(
    parameter int NUM_CH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [`SEQ_BITS-1:0]          bpkt_seq,
    output logic [NUM_CH-1:0]             bpkt_rq,
    input  logic [NUM_CH-1:0]             bpkt_gt,
    input  logic [NUM_CH-1:0]             bpkt_pres,
    input  logic [NUM_CH-1:0]             bpkt_pld,
    input  logic [NUM_CH*`PKT_BITS-1:0]   bpkt_data,
    input  logic                          vld_ack,
    input  logic                          vld_nak,
    input  logic [`SEQ_BITS-1:0]          ack_seq,
    output logic [NUM_CH*`PKT_BITS-1:0]   frm_data,
    output logic [NUM_CH-1:0]             frm_pres,
    output logic [NUM_CH-1:0]             frm_pld,
    output logic [`SEQ_BITS-1:0]          frm_seq,
    output logic                          frm_vld,
    input  logic                          frm_rdy
`ifdef SPIO_HSS_FRM_ASM_STATS_EN
    ,
    output logic [31:0]                   frm_cnt,
    output logic [15:0]                   nak_cnt
`endif
);

    localparam int SEQ_W = `SEQ_BITS;
    localparam int PKT_W = `PKT_BITS;
    localparam logic [SEQ_W-1:0] WIN_MAX = SEQ_W'(`BUF_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_GNT, S_CAP, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [SEQ_W-1:0]          seq_q, seq_d;
    logic [SEQ_W-1:0]          ack_base_q, ack_base_d;
    logic [SEQ_W-1:0]          outstanding;
    logic [NUM_CH-1:0]         pres_q, pres_d;
    logic [NUM_CH-1:0]         pld_q, pld_d;
    logic [NUM_CH-1:0]         frm_pres_q, frm_pres_d;
    logic [NUM_CH-1:0]         frm_pld_q, frm_pld_d;
    logic [NUM_CH*PKT_W-1:0]   frm_data_q, frm_data_d;
    logic [NUM_CH*PKT_W-1:0]   data_masked;
    logic [SEQ_W-1:0]          frm_seq_q, frm_seq_d;
    logic                      frm_vld_q, frm_vld_d;

    assign outstanding = seq_q - ack_base_q;

    always_comb begin
        data_masked = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (pres_q[ch]) data_masked[ch*PKT_W +: PKT_W] = bpkt_data[ch*PKT_W +: PKT_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        ack_base_d = ack_base_q;
        pres_d     = pres_q;
        pld_d      = pld_q;
        frm_pres_d = frm_pres_q;
        frm_pld_d  = frm_pld_q;
        frm_data_d = frm_data_q;
        frm_seq_d  = frm_seq_q;
        frm_vld_d  = frm_vld_q;
        case (state_q)
            S_IDLE: if (outstanding < WIN_MAX) state_d = S_REQ;
            S_REQ:  state_d = S_GNT;
            S_GNT: begin
                pres_d  = bpkt_pres & bpkt_gt;
                pld_d   = bpkt_pld;
                state_d = S_CAP;
            end
            S_CAP: begin
                frm_data_d = data_masked;
                if (pres_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    frm_pres_d = pres_q;
                    frm_pld_d  = pld_q;
                    frm_seq_d  = seq_q;
                    frm_vld_d  = 1'b1;
                    seq_d      = seq_q + 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: if (frm_rdy) begin
                frm_vld_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A nak rewinds the stores, so whatever is in flight is dropped and resent later.
        if (vld_nak) begin
            ack_base_d = ack_seq;
            seq_d      = ack_seq;
            frm_vld_d  = 1'b0;
            state_d    = S_IDLE;
        end else if (vld_ack) begin
            ack_base_d = ack_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            seq_q      <= '0;
            ack_base_q <= '0;
            pres_q     <= '0;
            pld_q      <= '0;
            frm_pres_q <= '0;
            frm_pld_q  <= '0;
            frm_data_q <= '0;
            frm_seq_q  <= '0;
            frm_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            ack_base_q <= ack_base_d;
            pres_q     <= pres_d;
            pld_q      <= pld_d;
            frm_pres_q <= frm_pres_d;
            frm_pld_q  <= frm_pld_d;
            frm_data_q <= frm_data_d;
            frm_seq_q  <= frm_seq_d;
            frm_vld_q  <= frm_vld_d;
        end
    end

    assign bpkt_seq = seq_q;
    assign bpkt_rq  = {NUM_CH{state_q == S_REQ}};
    assign frm_data = frm_data_q;
    assign frm_pres = frm_pres_q;
    assign frm_pld  = frm_pld_q;
    assign frm_seq  = frm_seq_q;
    assign frm_vld  = frm_vld_q;

`ifdef SPIO_HSS_FRM_ASM_STATS_EN
    logic [31:0] frm_cnt_q;
    logic [15:0] nak_cnt_q;
    logic        accept;

    assign accept = frm_vld_q && frm_rdy && !vld_nak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt_q <= '0;
            nak_cnt_q <= '0;
        end else begin
            if (accept && frm_cnt_q != '1) frm_cnt_q <= frm_cnt_q + 1'b1;
            if (vld_nak && nak_cnt_q != '1) nak_cnt_q <= nak_cnt_q + 1'b1;
        end
    end

    assign frm_cnt = frm_cnt_q;
    assign nak_cnt = nak_cnt_q;
`endif

endmodule
